store_buffer: RTL and testbench

Write-side counterpart to the CPU's even/odd bank read path. It accepts byte and word store requests from the execute stage and queues them in a small FIFO. Each entry is drained in order onto the two byte-bank write ports, splitting unaligned words across banks. Buffered bytes are forwarded to the load path so loads never observe stale memory.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/store_buffer_if.sv | 39 +++
 rtl/store_buffer_lane_split.sv | 53 +++++
 rtl/store_buffer.sv | 135 +++++++++++++
 tb/tb_store_buffer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: store size encoding and the buffered-store entry layout,
// plus byte-coverage helpers used by store forwarding.
package cpu_pkg;

  typedef enum logic {
    ST_BYTE = 1'b0,
    ST_WORD = 1'b1
  } store_size_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    store_size_t size;
  } store_entry_t;

  // A word store covers addr and addr+1 with 16-bit wrap.
  function automatic logic entry_covers(input store_entry_t e, input logic [15:0] a);
    logic [15:0] hi_addr;
    hi_addr = e.addr + 16'd1;
    return (e.addr == a) || ((e.size == ST_WORD) && (hi_addr == a));
  endfunction

  function automatic logic [7:0] entry_byte(input store_entry_t e, input logic [15:0] a);
    return (e.addr == a) ? e.data[7:0] : e.data[15:8];
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store-side bus: execute-stage store handshake, bank write ports,
// load forwarding lookup and occupancy status.
interface store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic          st_ready;
  logic [15:0]   st_addr;
  logic [15:0]   st_data;
  logic          st_word;
  logic          mem_write_allow;
  logic [14:0]   mem_write_addr_even;
  logic [7:0]    mem_write_data_even;
  logic          mem_write_en_even;
  logic [14:0]   mem_write_addr_odd;
  logic [7:0]    mem_write_data_odd;
  logic          mem_write_en_odd;
  logic [15:0]   fwd_addr;
  logic [1:0]    fwd_hit;
  logic [15:0]   fwd_data;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output st_valid, st_addr, st_data, st_word, mem_write_allow, fwd_addr,
    input  st_ready, mem_write_addr_even, mem_write_data_even, mem_write_en_even,
           mem_write_addr_odd, mem_write_data_odd, mem_write_en_odd,
           fwd_hit, fwd_data, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_word, mem_write_allow, fwd_addr,
    output st_ready, mem_write_addr_even, mem_write_data_even, mem_write_en_even,
           mem_write_addr_odd, mem_write_data_odd, mem_write_en_odd,
           fwd_hit, fwd_data, empty, count
  );
endinterface

// File: rtl/store_buffer_lane_split.sv
// Maps one buffered store onto the even/odd byte banks; an unaligned word
// puts its high byte in the even bank at the next word address.
module store_lane_split
  import cpu_pkg::*;
(
  input  store_entry_t entry,
  output logic         en_even,
  output logic         en_odd,
  output logic [14:0]  addr_even,
  output logic [14:0]  addr_odd,
  output logic [7:0]   data_even,
  output logic [7:0]   data_odd
);

  logic [14:0] base_s;
  logic [14:0] base_next_s;

  // Lane selection from size and byte offset
  always_comb begin
    base_s      = entry.addr[15:1];
    base_next_s = base_s + 15'd1;
    en_even     = 1'b0;
    en_odd      = 1'b0;
    addr_even   = base_s;
    addr_odd    = base_s;
    data_even   = entry.data[7:0];
    data_odd    = entry.data[7:0];
    case ({entry.size == ST_WORD, entry.addr[0]})
      2'b00: begin
        en_even = 1'b1;
      end
      2'b01: begin
        en_odd = 1'b1;
      end
      2'b10: begin
        en_even  = 1'b1;
        en_odd   = 1'b1;
        data_odd = entry.data[15:8];
      end
      2'b11: begin
        en_even   = 1'b1;
        en_odd    = 1'b1;
        addr_even = base_next_s;
        data_even = entry.data[15:8];
      end
      default: begin
        en_even = 1'b0;
        en_odd  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO that drains one entry per cycle onto the byte banks
// and forwards buffered bytes (youngest wins) to the load path.
module store_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  store_entry_t   mem_q [DEPTH];
  store_entry_t   mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic           empty_s;
  logic           ready_s;
  logic           push_s;
  logic           pop_s;
  store_entry_t   new_entry_s;
  store_entry_t   head_s;
  logic           split_en_even_s;
  logic           split_en_odd_s;
  logic [PW-1:0]  fwd_idx_s;
  logic [15:0]    lane_addr_s [2];
  logic [1:0]     fwd_hit_s;
  logic [15:0]    fwd_data_s;
  logic           cover_s;

  // Handshake and drain qualification
  always_comb begin
    empty_s     = (count_q == {CW{1'b0}});
    ready_s     = !reset && (count_q != FULL_COUNT);
    push_s      = bus.st_valid && ready_s;
    pop_s       = !reset && !empty_s && bus.mem_write_allow;
    new_entry_s = '{addr: bus.st_addr,
                    data: bus.st_data,
                    size: (bus.st_word ? ST_WORD : ST_BYTE)};
    head_s      = mem_q[rd_ptr_q];
  end

  // Next-state for entries, pointers and occupancy
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (push_s) begin
      mem_d[wr_ptr_q]   = new_entry_s;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= {DEPTH{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload storage; qualified by valid_q so no reset needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  store_lane_split u_split (
    .entry     (head_s),
    .en_even   (split_en_even_s),
    .en_odd    (split_en_odd_s),
    .addr_even (bus.mem_write_addr_even),
    .addr_odd  (bus.mem_write_addr_odd),
    .data_even (bus.mem_write_data_even),
    .data_odd  (bus.mem_write_data_odd)
  );

  // Forwarding: scan oldest to youngest so younger matches overwrite older
  always_comb begin
    lane_addr_s[0] = bus.fwd_addr;
    lane_addr_s[1] = bus.fwd_addr + 16'd1;
    fwd_hit_s      = 2'b00;
    fwd_data_s     = 16'h0000;
    fwd_idx_s      = rd_ptr_q;
    cover_s        = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx_s = rd_ptr_q + PW'(k);
      for (int l = 0; l < 2; l++) begin
        cover_s             = !reset && valid_q[fwd_idx_s] &&
                              entry_covers(mem_q[fwd_idx_s], lane_addr_s[l]);
        fwd_hit_s[l]        = fwd_hit_s[l] | cover_s;
        fwd_data_s[l*8 +: 8] = cover_s ? entry_byte(mem_q[fwd_idx_s], lane_addr_s[l])
                                       : fwd_data_s[l*8 +: 8];
      end
    end
  end

  // Output drive
  always_comb begin
    bus.st_ready          = ready_s;
    bus.mem_write_en_even = pop_s && split_en_even_s;
    bus.mem_write_en_odd  = pop_s && split_en_odd_s;
    bus.fwd_hit           = fwd_hit_s;
    bus.fwd_data          = fwd_data_s;
    bus.empty             = empty_s;
    bus.count             = count_q;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected bank writes are queued as stores
// are accepted and compared in order as the buffer drains.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        en_e;
    logic        en_o;
    logic [14:0] ae;
    logic [14:0] ao;
    logic [7:0]  de;
    logic [7:0]  dd;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic armed;
  logic rand_allow;
  exp_t sb_q[$];

  store_buffer_if #(.DEPTH(DEPTH)) bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte-address model: byte a lands in bank a[0] at word a[15:1].
  function automatic exp_t place(input exp_t e, input logic [15:0] a, input logic [7:0] d);
    exp_t r;
    r = e;
    if (a[0]) begin
      r.en_o = 1'b1; r.ao = a[15:1]; r.dd = d;
    end else begin
      r.en_e = 1'b1; r.ae = a[15:1]; r.de = d;
    end
    return r;
  endfunction

  function automatic exp_t make_exp(input logic [15:0] a, input logic [15:0] d, input logic w);
    exp_t e;
    logic [15:0] a1;
    e  = '0;
    a1 = a + 16'd1;
    e  = place(e, a, d[7:0]);
    if (w) e = place(e, a1, d[15:8]);
    return e;
  endfunction

  task automatic do_store(input logic [15:0] a, input logic [15:0] d, input logic w);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    bus.st_valid = 1'b1; bus.st_addr = a; bus.st_data = d; bus.st_word = w;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (bus.st_ready === 1'b1) begin
        sb_q.push_back(make_exp(a, d, w));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.st_valid = 1'b0;
    if (!done) chk("store_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 80 && !done; t++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0 && bus.empty === 1'b1) done = 1'b1;
    end
    chk("drain_complete", 32'(done), 32'(1));
  endtask

  // Scoreboard monitor: every observed bank write must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (armed && (bus.mem_write_en_even !== 1'b0 || bus.mem_write_en_odd !== 1'b0)) begin
      if (sb_q.size() == 0) begin
        chk("drain_unexpected", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        chk("drain_en", 32'({bus.mem_write_en_even, bus.mem_write_en_odd}), 32'({e.en_e, e.en_o}));
        if (e.en_e) begin
          chk("drain_addr_even", 32'(bus.mem_write_addr_even), 32'(e.ae));
          chk("drain_data_even", 32'(bus.mem_write_data_even), 32'(e.de));
        end
        if (e.en_o) begin
          chk("drain_addr_odd", 32'(bus.mem_write_addr_odd), 32'(e.ao));
          chk("drain_data_odd", 32'(bus.mem_write_data_odd), 32'(e.dd));
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_allow) begin
      #1 bus.mem_write_allow = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    checks = 0; failures = 0; armed = 1'b0; rand_allow = 1'b0;
    reset = 1'b1;
    bus.st_valid = 1'b0; bus.st_addr = 16'h0; bus.st_data = 16'h0; bus.st_word = 1'b0;
    bus.mem_write_allow = 1'b0; bus.fwd_addr = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", 32'(bus.st_ready), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_empty", 32'(bus.empty), 32'(1));
    chk("reset_count", 32'(bus.count), 32'(0));
    chk("reset_ready", 32'(bus.st_ready), 32'(1));
    chk("reset_en", 32'({bus.mem_write_en_even, bus.mem_write_en_odd}), 32'(0));
    chk("reset_fwd_hit", 32'(bus.fwd_hit), 32'(0));
    armed = 1'b1;

    // Odd byte: drains on the next cycle
    bus.mem_write_allow = 1'b1;
    do_store(16'h4001, 16'h55AB, 1'b0);
    @(negedge clk);
    chk("byte_en_odd", 32'(bus.mem_write_en_odd), 32'(1));
    chk("byte_en_even", 32'(bus.mem_write_en_even), 32'(0));
    chk("byte_addr_odd", 32'(bus.mem_write_addr_odd), 32'(15'h2000));
    chk("byte_data_odd", 32'(bus.mem_write_data_odd), 32'(8'hAB));
    @(negedge clk);
    chk("byte_empty_after", 32'(bus.empty), 32'(1));

    // Unaligned word at the top of memory wraps its high byte to even word 0
    do_store(16'hFFFF, 16'h1234, 1'b1);
    @(negedge clk);
    chk("wrap_en", 32'({bus.mem_write_en_even, bus.mem_write_en_odd}), 32'(2'b11));
    chk("wrap_addr_odd", 32'(bus.mem_write_addr_odd), 32'(15'h7FFF));
    chk("wrap_data_odd", 32'(bus.mem_write_data_odd), 32'(8'h34));
    chk("wrap_addr_even", 32'(bus.mem_write_addr_even), 32'(15'h0000));
    chk("wrap_data_even", 32'(bus.mem_write_data_even), 32'(8'h12));
    wait_drain();

    // Fill to capacity with drains blocked, then release
    bus.mem_write_allow = 1'b0;
    do_store(16'h1000, 16'hA1A2, 1'b1);
    do_store(16'h1003, 16'hB1B2, 1'b1);
    do_store(16'h2002, 16'hC1C2, 1'b0);
    do_store(16'h2005, 16'hD1D2, 1'b0);
    @(posedge clk); #1;
    bus.st_valid = 1'b1; bus.st_addr = 16'h3000; bus.st_data = 16'hE1E2; bus.st_word = 1'b1;
    @(negedge clk);
    chk("full_ready", 32'(bus.st_ready), 32'(0));
    chk("full_count", 32'(bus.count), 32'(4));
    bus.mem_write_allow = 1'b1;
    do_store(16'h3000, 16'hE1E2, 1'b1);
    wait_drain();
    chk("full_drained_count", 32'(bus.count), 32'(0));

    // Forwarding with drains blocked
    bus.mem_write_allow = 1'b0;
    do_store(16'h4000, 16'h1111, 1'b1);
    do_store(16'h4001, 16'h0022, 1'b0);
    bus.fwd_addr = 16'h4000;
    @(negedge clk);
    chk("fwd_hit_4000", 32'(bus.fwd_hit), 32'(2'b11));
    chk("fwd_data_4000", 32'(bus.fwd_data), 32'(16'h2211));
    bus.fwd_addr = 16'h3FFF;
    @(negedge clk);
    chk("fwd_hit_3fff", 32'(bus.fwd_hit), 32'(2'b10));
    chk("fwd_data_3fff_hi", 32'(bus.fwd_data[15:8]), 32'(8'h11));
    bus.fwd_addr = 16'h4002;
    @(negedge clk);
    chk("fwd_hit_4002", 32'(bus.fwd_hit), 32'(2'b00));

    // A store being accepted is not yet forwarded
    bus.fwd_addr = 16'h5000;
    @(posedge clk); #1;
    bus.st_valid = 1'b1; bus.st_addr = 16'h5000; bus.st_data = 16'h00CD; bus.st_word = 1'b0;
    @(negedge clk);
    chk("fwd_same_cycle", 32'(bus.fwd_hit), 32'(0));
    chk("fwd_same_cycle_ready", 32'(bus.st_ready), 32'(1));
    sb_q.push_back(make_exp(16'h5000, 16'h00CD, 1'b0));
    @(posedge clk); #1;
    bus.st_valid = 1'b0;
    @(negedge clk);
    chk("fwd_next_cycle_hit", 32'(bus.fwd_hit), 32'(2'b01));
    chk("fwd_next_cycle_data", 32'(bus.fwd_data[7:0]), 32'(8'hCD));
    chk("pre_reset_count", 32'(bus.count), 32'(3));

    // Reset while a drain is permitted discards everything
    @(posedge clk); #1;
    bus.mem_write_allow = 1'b1;
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("rst_ready", 32'(bus.st_ready), 32'(0));
    chk("rst_en", 32'({bus.mem_write_en_even, bus.mem_write_en_odd}), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(bus.count), 32'(0));
    chk("rst_empty", 32'(bus.empty), 32'(1));
    chk("rst_fwd_hit", 32'(bus.fwd_hit), 32'(0));
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_write", 32'({bus.mem_write_en_even, bus.mem_write_en_odd}), 32'(0));
    end

    // Random traffic with random drain permission
    rand_allow = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_store(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(posedge clk);
    end
    rand_allow = 1'b0;
    @(posedge clk); #2;
    bus.mem_write_allow = 1'b1;
    wait_drain();
    chk("final_count", 32'(bus.count), 32'(0));
    chk("final_queue", 32'(sb_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
